// File: rtl/mem_arbiter_n_pkg.sv
// Shared definitions for the N-port memory request arbiter: op codes,
// controller states, message lengths and the request message packer.
package mem_arbiter_n_pkg;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    DONE
  } state_t;

  localparam int unsigned REQ_LEN_READ  = 5;
  localparam int unsigned REQ_LEN_WRITE = 9;
  localparam int unsigned RSP_LEN_READ  = 4;
  localparam int unsigned RSP_LEN_WRITE = 1;

  // Minimum message width needed for the largest (write) request
  localparam int unsigned REQ_MSG_W = 72;

  // Build the little-endian request message: opcode byte, 4 address bytes,
  // and 4 data bytes for writes only; every unused bit stays zero.
  function automatic logic [REQ_MSG_W-1:0] pack_req(
    input op_t         op,
    input logic [3:0]  mask,
    input logic [31:0] addr,
    input logic [31:0] data
  );
    logic [REQ_MSG_W-1:0] m;
    m        = '0;
    m[7:0]   = {mask, 2'b00, op};
    m[39:8]  = addr;
    if (op == OP_WRITE) begin
      m[71:40] = data;
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_arbiter_n_rr_picker.sv
// Combinational round-robin selector: returns the first requesting port
// found when searching rr_ptr, rr_ptr+1, ... modulo PORTS.
module mem_arbiter_n_rr_picker
  import mem_arbiter_n_pkg::*;
#(
  parameter int unsigned PORTS = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic [PORTS-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [PTR_W-1:0] grant,
  output logic             any_valid
);

  int unsigned idx;

  // Scan from the farthest offset down so the port nearest rr_ptr wins last
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < PORTS; off++) begin
      idx = (32'(rr_ptr) + PORTS - 1 - off) % PORTS;
      if (req[idx[PTR_W-1:0]]) begin
        grant     = idx[PTR_W-1:0];
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-port memory request arbiter: grants one requester at a time in
// round-robin order, packs the request into one channel message, waits for
// the host reply (optionally re-sending on timeout) and returns the result.
module mem_arbiter_n
  import mem_arbiter_n_pkg::*;
#(
  parameter int unsigned PORTS        = 2,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MSG_BIT      = 72,
  parameter int unsigned LEN_W        = 5,
  parameter int unsigned RETRY_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2*PORTS-1:0]       rw_flag,
  input  logic [ADDR_W*PORTS-1:0]  addr,
  input  logic [DATA_W*PORTS-1:0]  write_data,
  input  logic [4*PORTS-1:0]       write_mask,
  output logic [DATA_W*PORTS-1:0]  read_data,
  output logic [PORTS-1:0]         busy,
  output logic [PORTS-1:0]         done,
  output logic                     comm_write_flag,
  output logic [MSG_BIT-1:0]       comm_write_data,
  output logic [LEN_W-1:0]         comm_write_length,
  input  logic                     comm_writable,
  output logic                     comm_read_flag,
  input  logic [MSG_BIT-1:0]       comm_read_data,
  input  logic [LEN_W-1:0]         comm_read_length,
  input  logic                     comm_readable
);

  localparam int unsigned PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int unsigned TMR_W = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;

  state_t                         state_q, state_d;
  logic [PTR_W-1:0]               port_q, port_d;
  op_t                            op_q, op_d;
  logic [MSG_BIT-1:0]             msg_q, msg_d;
  logic [LEN_W-1:0]               len_q, len_d;
  logic [PORTS-1:0]               busy_q, busy_d;
  logic [PORTS-1:0]               done_q, done_d;
  logic [PTR_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic [TMR_W-1:0]               timer_q, timer_d;
  logic [PORTS-1:0][DATA_W-1:0]   read_data_q, read_data_d;

  logic [PORTS-1:0]               req_vec;
  logic [PTR_W-1:0]               grant;
  logic                           any_valid;
  logic [1:0]                     sel_rw;
  logic [ADDR_W-1:0]              sel_addr;
  logic [DATA_W-1:0]              sel_data;
  logic [3:0]                     sel_mask;
  logic [LEN_W-1:0]               rsp_len;
  logic                           unused_rsp_bits;

  assign unused_rsp_bits = ^comm_read_data[MSG_BIT-1:32];

  // Only read and write codes count as requests; 11 is treated as idle
  always_comb begin
    req_vec = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      req_vec[i] = (rw_flag[i*2 +: 2] == OP_READ) || (rw_flag[i*2 +: 2] == OP_WRITE);
    end
  end

  mem_arbiter_n_rr_picker #(
    .PORTS (PORTS),
    .PTR_W (PTR_W)
  ) u_picker (
    .req       (req_vec),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .any_valid (any_valid)
  );

  // Mux the granted port's request fields
  always_comb begin
    sel_rw   = '0;
    sel_addr = '0;
    sel_data = '0;
    sel_mask = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (grant == PTR_W'(i)) begin
        sel_rw   = rw_flag[i*2 +: 2];
        sel_addr = addr[i*ADDR_W +: ADDR_W];
        sel_data = write_data[i*DATA_W +: DATA_W];
        sel_mask = write_mask[i*4 +: 4];
      end
    end
  end

  assign rsp_len = (op_q == OP_READ) ? LEN_W'(RSP_LEN_READ) : LEN_W'(RSP_LEN_WRITE);

  // Next-state logic for the grant / send / wait / done sequence
  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    op_d        = op_q;
    msg_d       = msg_q;
    len_d       = len_q;
    busy_d      = busy_q;
    done_d      = '0;
    rr_ptr_d    = rr_ptr_q;
    timer_d     = timer_q;
    read_data_d = read_data_q;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          port_d        = grant;
          op_d          = op_t'(sel_rw);
          msg_d         = MSG_BIT'(pack_req(op_t'(sel_rw), sel_mask, 32'(sel_addr), 32'(sel_data)));
          len_d         = (sel_rw == OP_WRITE) ? LEN_W'(REQ_LEN_WRITE) : LEN_W'(REQ_LEN_READ);
          busy_d        = '0;
          busy_d[grant] = 1'b1;
          state_d       = SEND;
        end
      end
      SEND: begin
        if (comm_writable) begin
          timer_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        if (comm_readable) begin
          // Wrong-length replies are popped and dropped; a pop also
          // suppresses any retry due in the same cycle
          if (comm_read_length == rsp_len) begin
            done_d[port_q] = 1'b1;
            state_d        = DONE;
            if (op_q == OP_READ) begin
              read_data_d[port_q] = DATA_W'(comm_read_data[31:0]);
            end
          end
        end else if ((RETRY_CYCLES > 0) && (timer_q == TMR_W'(RETRY_CYCLES - 1))) begin
          state_d = SEND;
        end
      end
      DONE: begin
        busy_d   = '0;
        rr_ptr_d = (port_q == PTR_W'(PORTS - 1)) ? '0 : port_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      port_q      <= '0;
      op_q        <= OP_IDLE;
      msg_q       <= '0;
      len_q       <= '0;
      busy_q      <= '0;
      done_q      <= '0;
      rr_ptr_q    <= '0;
      timer_q     <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      op_q        <= op_d;
      msg_q       <= msg_d;
      len_q       <= len_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rr_ptr_q    <= rr_ptr_d;
      timer_q     <= timer_d;
      read_data_q <= read_data_d;
    end
  end

  // Push/pop strobes qualify the registered state with the channel's
  // same-cycle ready signals so each transfer is exactly one cycle long
  assign comm_write_flag   = (state_q == SEND) && comm_writable;
  assign comm_read_flag    = (state_q == WAIT) && comm_readable;
  assign comm_write_data   = msg_q;
  assign comm_write_length = len_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign read_data         = read_data_q;

endmodule

// File: doc/mem_arbiter_n.md
Name: mem_arbiter_n

Overview:
- N-port memory request arbiter between several requesters (instruction fetch, data port, future DMA) and one message channel of the multi-channel UART communication block.
- Generalised successor of the fixed two-port memory controller: parametrised port count and widths, round-robin fairness, byte-mask writes and response-length checking.
- Adds a retry-on-timeout mode.
- Packs each granted request into one outbound message, waits for the host reply, and returns data/done to the granted port.

Parameters:
- PORTS, 2: number of requester ports (≥ 2).
- ADDR_W, 32: address width (packed as 4 bytes; upper bits zero if ADDR_W < 32).
- DATA_W, 32: data width (4 bytes).
- MSG_BIT, 72: message width of the channel (≥ 72).
- LEN_W, 5: message length field width (bytes).
- RETRY_CYCLES, 0: WAIT cycles before the request is re-sent; 0 disables retry.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset: asynchronous, active-low.
- rw_flag  in  2*PORTS  per port: 00 idle, 01 read, 10 write, 11 ignored (treated as idle).
- addr  in  ADDR_W*PORTS  per-port address.
- write_data  in  DATA_W*PORTS  per-port write data.
- write_mask  in  4*PORTS  per-port byte enables.
- read_data  out  DATA_W*PORTS  per-port read result; held until that port's next read completes.
- busy  out  PORTS  request granted and in flight.
- done  out  PORTS  one-cycle completion pulse.
- comm_write_flag  out  1  push one message to the channel.
- comm_write_data  out  MSG_BIT  outbound message, little-endian bytes, byte0 = bits[7:0].
- comm_write_length  out  LEN_W  outbound byte count.
- comm_writable  in  1  channel accepts a push this cycle.
- comm_read_flag  out  1  pop one inbound message.
- comm_read_data  in  MSG_BIT  inbound message; valid while comm_readable.
- comm_read_length  in  LEN_W  inbound byte count.
- comm_readable  in  1  inbound message available.

Behaviour:
- Reset values: all outputs, state, latches and the retry timer are 0; state IDLE; rr_ptr 0.
  - Reset mid-operation abandons the in-flight request: no done pulse, busy cleared immediately.
- Requester handshake:
  - rw_flag, addr, write_data and write_mask are held stable until done.
  - The requester must drop or change rw_flag on the done cycle.
  - No port is sampled in state DONE.
- IDLE: pick the first port with rw_flag ∈ {01, 10}, searching rr_ptr, rr_ptr+1, … mod PORTS.
  - Latch port id, op, addr, data and mask; set busy[g] <= 1; go SEND.
  - No request: stay in IDLE.
- SEND: when comm_writable, assert comm_write_flag for exactly one cycle; clear timer; go WAIT. Otherwise hold.
  - Opcode byte0 = {mask[3:0], 2'b00, op[1:0]}.
  - Read message: byte0 opcode, bytes1-4 address; length 5.
  - Write message: byte0 opcode, bytes1-4 address, bytes5-8 data; length 9.
  - Unused message bits are 0.
- WAIT: timer increments every cycle.
  - If comm_readable: assert comm_read_flag for one cycle.
    - Expected length (4 for a read, 1 for a write): go DONE; for a read, capture bytes0-3 into read_data[g].
    - Any other length: message discarded; stay in WAIT.
  - If RETRY_CYCLES > 0, timer == RETRY_CYCLES-1 and no message is popped this cycle: go SEND and re-send the identical message.
  - A pop takes priority over a retry in the same cycle.
- DONE: done[g] = 1 for one cycle; busy[g] <= 0; rr_ptr <= (g+1) mod PORTS; go IDLE.
  - Earliest re-grant is the cycle after done.
- Minimum latency with an immediately ready channel:
  - request seen in IDLE at T; SEND push at T+1;
  - reply pop at the first readable cycle ≥ T+2; done at pop+1.
- Exactly one request is in flight; all other busy bits stay 0.
- Timer and rr_ptr wrap naturally; rr_ptr width is clog2(PORTS).

Decomposition:
- Shared defines header holds:
  - op codes OP_IDLE/OP_READ/OP_WRITE;
  - state encodings IDLE/SEND/WAIT/DONE;
  - REQ_LEN_READ=5, REQ_LEN_WRITE=9, RSP_LEN_READ=4, RSP_LEN_WRITE=1.
- One sub-module: rr_picker, a combinational round-robin priority selector.
  - Inputs: request vector, rr_ptr.
  - Outputs: grant index, any_valid.

Test Plan:
- Port0 read addr 0x00001000, channel always ready:
  - push length 5, data 0x0000100001;
  - reply length 4, data 0xDEADBEEF;
  - done[0] one cycle; read_data[0] = 0xDEADBEEF.
- Port1 write 0x12345678 to 0x20 with mask 0xF:
  - push length 9, bytes 0xF2,0x20,0,0,0,0x78,0x56,0x34,0x12;
  - reply length 1 → done[1] pulse.
- Port0 and Port1 requesting continuously:
  - grants alternate 0,1,0,1;
  - busy never high on both ports.
- comm_writable low for 10 cycles: no push, state held; single push once writable.
- RETRY_CYCLES=8, no reply: identical message re-pushed every 9 cycles.
  - A reply with length 3 is popped and ignored.
  - A later length-4 reply completes the read.
- rst low during WAIT: busy/done/comm flags go 0 asynchronously.
  - After release, a new request is served from port 0 priority.
